// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- two-entry skid-buffered pipeline stage register.
//
// A main register drives the downstream side. A skid register catches one
// extra payload so that in_ready depends only on local state and the
// freeze/flush controls, never combinationally on out_ready.
//
// Parameters:
//   WIDTH      payload width in bits
//   CNT_WIDTH  width of each performance counter (PIPE_STAGE_PERF_EN only)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      discard all held entries and the same-cycle input
//   freeze     hazard stall, hold all state, no transfers
//   in_valid   upstream offers in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to downstream, zero when out_valid=0
//   stall_cnt  saturating stall-cycle counter      (PIPE_STAGE_PERF_EN only)
//   flush_cnt  saturating discarding-flush counter (PIPE_STAGE_PERF_EN only)
//
// Optional feature macro: PIPE_STAGE_PERF_EN enables the two counters.

module pipe_stage_reg #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 freeze,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               main_valid, skid_valid;
    logic               in_fire, out_fire;

    // Valid bits are decoded from the state, so skid can never be valid
    // while main is empty.
    always_comb begin
        main_valid = (state_q != EMPTY);
        skid_valid = (state_q == TWO);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state logic. freeze needs no explicit branch: it already blocks
    // both in_fire and out_fire, so every register holds.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Outputs and handshakes
    always_comb begin
        in_ready  = ~skid_valid & ~freeze & ~flush;
        out_valid = main_valid;
        out_data  = main_valid ? main_q : '0;
        in_fire   = in_valid & in_ready;
        out_fire  = main_valid & out_ready & ~freeze & ~flush;
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (((main_valid & ~out_ready) | freeze) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush && main_valid && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        stall_cnt = stall_q;
        flush_cnt = flush_q;
    end
`else
    // Keeps CNT_WIDTH referenced when the counters are compiled out.
    logic [CNT_WIDTH-1:0] unused_cnt_w;
    always_comb unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned TB_W     = 64;
    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst, flush, freeze, in_valid, in_ready, out_valid, out_ready;
    logic [TB_W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of at most two accepted payloads
    logic [TB_W-1:0] q[$];
    int              stall_m = 0;
    int              flush_m = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH    (TB_W),
        .CNT_WIDTH(TB_CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .freeze   (freeze),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model at the
    // falling edge, then advance the model across the rising edge.
    task automatic step(input logic r, input logic fl, input logic fz,
                        input logic iv, input logic orr, input logic [TB_W-1:0] d);
        logic            rdy;
        logic [TB_W-1:0] exp_d;
        rst = r; flush = fl; freeze = fz; in_valid = iv; out_ready = orr; in_data = d;
        @(negedge clk);
        exp_d = (q.size() > 0) ? q[0] : '0;
        check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check_eq("out_data", out_data, exp_d);
        check_eq("in_ready", 64'(in_ready), 64'((q.size() < 2) && !fz && !fl));
`ifdef PIPE_STAGE_PERF_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        check_eq("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
        @(posedge clk);
        if (r) begin
            q.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            if ((((q.size() > 0) && !orr) || fz) && stall_m < CNT_MAX) stall_m++;
            if (fl && (q.size() > 0) && flush_m < CNT_MAX) flush_m++;
            if (fl) begin
                q.delete();
            end else if (!fz) begin
                rdy = (q.size() < 2);
                if ((q.size() > 0) && orr) void'(q.pop_front());
                if (iv && rdy) q.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        logic [TB_W-1:0] rd;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, idle
        step(0, 0, 0, 0, 0, '0);

        // Streaming 1..8 with out_ready held high, then drain
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 1, 64'(i));
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);

        // Backpressure: fill with 0xA, 0xB, hold, then drain
        step(0, 0, 0, 1, 0, 64'hA);
        step(0, 0, 0, 1, 0, 64'hB);
        step(0, 0, 0, 1, 0, 64'hC);
        check_eq("bp_two_data", out_data, 64'hA);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);

        // Freeze in ONE holding 0x5
        step(0, 0, 0, 1, 0, 64'h5);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 64'h77);
        check_eq("freeze_hold", out_data, 64'h5);
        step(0, 0, 0, 0, 1, '0);

        // Flush from TWO with freeze and in_valid also high
        step(0, 0, 0, 1, 0, 64'h11);
        step(0, 0, 0, 1, 0, 64'h22);
        step(0, 1, 1, 1, 1, 64'h33);
        step(0, 0, 0, 0, 0, '0);
        check_eq("flush_empty", out_data, 64'h0);

        // Reset from TWO
        step(0, 0, 0, 1, 0, 64'h44);
        step(0, 0, 0, 1, 0, 64'h55);
        step(1, 0, 0, 1, 1, 64'h66);
        step(0, 0, 0, 0, 0, '0);

        // Counter saturation: one entry stalled for 20 cycles
        step(0, 0, 0, 1, 0, 64'h99);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, '0);
`ifdef PIPE_STAGE_PERF_EN
        check_eq("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        step(1, 0, 0, 0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom(), $urandom()};
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60),
                 rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
